// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage pipeline: load-use stalls,
// branch/jump flushes, data-memory waits and a stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int REG_W   = 3,
  parameter int CNT_W   = 16,
  parameter int MEM_TMO = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             jump_id,
  input  logic             branch_ex,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pipe_hold,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] LD_STALL = 2'd1;
  localparam logic [1:0] MEM_WAIT = 2'd2;

  localparam int TW = $clog2(MEM_TMO + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TMO - 1);

  logic [1:0]    state;
  logic [1:0]    nxt;
  logic [TW-1:0] tmo;
  logic          err;
  logic          mem_stall;
  logic          load_use;
  logic          wait_hit;
  logic          tmo_hit;

  assign mem_stall = mem_req & ~mem_ready;
  assign load_use  = ex_mem_read &
                     ((id_use_rs & (id_rs == ex_rd)) |
                      (id_use_rt & (id_rt == ex_rd)));
  assign wait_hit  = (state == MEM_WAIT) & mem_stall;
  assign tmo_hit   = wait_hit & (tmo == TMO_LAST);
  assign mem_err   = err & ~rst;

  // Control outputs and next state from current state and hazard inputs
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    pipe_hold    = 1'b0;
    nxt          = RUN;
    if (!rst) begin
      if (mem_stall) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        pipe_hold   = 1'b1;
        nxt         = tmo_hit ? RUN : MEM_WAIT;
      end else if (state != LD_STALL) begin
        priority case (1'b1)
          branch_ex: begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end
          jump_id: if_id_flush = 1'b1;
          load_use: begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            nxt          = LD_STALL;
          end
          default: nxt = RUN;
        endcase
      end
    end
  end

  // State, memory-wait timeout, sticky error and stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      tmo       <= '0;
      err       <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= nxt;
      if (wait_hit && !tmo_hit) tmo <= tmo + TW'(1);
      else                      tmo <= '0;
      if (tmo_hit) err <= 1'b1;
      if (!pc_write && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed
// scenarios plus randomized traffic against a behavioural model.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] id_rs, id_rt, ex_rd;
  logic       id_use_rs, id_use_rt, ex_mem_read;
  logic       jump_id, branch_ex, mem_req, mem_ready;

  logic        pc_write, if_id_write, id_ex_bubble;
  logic        if_id_flush, id_ex_flush, pipe_hold, mem_err;
  logic [15:0] stall_cnt;

  logic        s_pc_write, s_if_id_write, s_id_ex_bubble;
  logic        s_if_id_flush, s_id_ex_flush, s_pipe_hold, s_mem_err;
  logic [3:0]  s_stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // model: mode 0=running, 1=after load-use stall, 2=waiting on memory
  int m_mode = 0;
  int m_wait = 0;
  bit m_err  = 0;
  int m_cnt  = 0;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .jump_id(jump_id), .branch_ex(branch_ex),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .pipe_hold(pipe_hold),
    .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  pipeline_hazard_ctrl #(.CNT_W(4)) sdut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .jump_id(jump_id), .branch_ex(branch_ex),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(s_pc_write), .if_id_write(s_if_id_write),
    .id_ex_bubble(s_id_ex_bubble), .if_id_flush(s_if_id_flush),
    .id_ex_flush(s_id_ex_flush), .pipe_hold(s_pipe_hold),
    .mem_err(s_mem_err), .stall_cnt(s_stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] got();
    return {pc_write, if_id_write, id_ex_bubble, if_id_flush,
            id_ex_flush, pipe_hold, mem_err};
  endfunction

  function automatic logic [6:0] s_got();
    return {s_pc_write, s_if_id_write, s_id_ex_bubble, s_if_id_flush,
            s_id_ex_flush, s_pipe_hold, s_mem_err};
  endfunction

  function automatic bit mstall();
    return mem_req && !mem_ready;
  endfunction

  function automatic bit luse();
    return ex_mem_read && ((id_use_rs && id_rs == ex_rd) ||
                           (id_use_rt && id_rt == ex_rd));
  endfunction

  // {pc, ifid, bubble, ifflush, idflush, hold, err}
  function automatic logic [6:0] exp_out();
    logic [6:0] o;
    if (rst) return 7'b1100000;
    if (mstall())                 o = 7'b0000010;
    else if (m_mode == 1)         o = 7'b1100000;
    else if (branch_ex)           o = 7'b1101100;
    else if (jump_id)             o = 7'b1101000;
    else if (luse())              o = 7'b0010000;
    else                          o = 7'b1100000;
    o[0] = m_err;
    return o;
  endfunction

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk) begin
    logic [6:0] o;
    o = exp_out();
    if (rst) begin
      m_mode = 0; m_wait = 0; m_err = 0; m_cnt = 0;
    end else begin
      if (!o[6]) m_cnt++;
      if (mstall()) begin
        if (m_mode == 2) begin
          m_wait++;
          if (m_wait == 15) begin
            m_err = 1; m_mode = 0; m_wait = 0;
          end
        end else begin
          m_mode = 2; m_wait = 0;
        end
      end else begin
        m_wait = 0;
        m_mode = (m_mode != 1 && !branch_ex && !jump_id && luse()) ? 1 : 0;
      end
    end
  end

  task automatic set_idle();
    id_rs = 0; id_rt = 0; ex_rd = 0;
    id_use_rs = 0; id_use_rt = 0; ex_mem_read = 0;
    jump_id = 0; branch_ex = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_req = 1; mem_ready = 0; branch_ex = 1; jump_id = 1;
    @(negedge clk);
    n_chk++;
    if (got() !== 7'b1100000) begin
      n_fail++;
      $display("FAIL reset_outs got %b need %b", got(), 7'b1100000);
    end
    next_cyc();
    rst = 1'b0;
    set_idle();
    @(negedge clk);
    n_chk++;
    if (got() !== 7'b1100000 || stall_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state got %b cnt %0d need 1100000 cnt 0",
               got(), stall_cnt);
    end
    next_cyc();
  endtask

  task automatic test_load_use(input bit use_rs);
    do_reset();
    ex_mem_read = 1; ex_rd = 3; id_rs = 3; id_use_rs = use_rs;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_chk++;
      if (got() !== exp_out()) begin
        n_fail++;
        $display("FAIL load_use%0d cyc%0d got %b need %b",
                 use_rs, c, got(), exp_out());
      end
      next_cyc();
    end
    set_idle();
    @(negedge clk);
    n_chk++;
    if (got() !== 7'b1100000 || stall_cnt !== 16'(use_rs)) begin
      n_fail++;
      $display("FAIL load_use%0d_after got %b cnt %0d need 1100000 cnt %0d",
               use_rs, got(), stall_cnt, use_rs);
    end
    next_cyc();
  endtask

  task automatic test_branch_priority();
    do_reset();
    ex_mem_read = 1; ex_rd = 5; id_rt = 5; id_use_rt = 1; branch_ex = 1;
    @(negedge clk);
    n_chk++;
    if (got() !== 7'b1101100) begin
      n_fail++;
      $display("FAIL branch_prio got %b need %b", got(), 7'b1101100);
    end
    next_cyc();
    branch_ex = 0;
    @(negedge clk);
    n_chk++;
    if (got() !== 7'b0010000) begin
      n_fail++;
      $display("FAIL branch_then_lu got %b need %b", got(), 7'b0010000);
    end
    next_cyc();
    set_idle();
  endtask

  task automatic test_jump();
    do_reset();
    jump_id = 1;
    @(negedge clk);
    n_chk++;
    if (got() !== 7'b1101000) begin
      n_fail++;
      $display("FAIL jump got %b need %b", got(), 7'b1101000);
    end
    next_cyc();
    jump_id = 0;
    @(negedge clk);
    n_chk++;
    if (got() !== 7'b1100000) begin
      n_fail++;
      $display("FAIL jump_after got %b need %b", got(), 7'b1100000);
    end
    next_cyc();
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_chk++;
      if (got() !== 7'b0000010) begin
        n_fail++;
        $display("FAIL mem_wait cyc%0d got %b need %b", c, got(), 7'b0000010);
      end
      next_cyc();
    end
    mem_ready = 1;
    @(negedge clk);
    n_chk++;
    if (got() !== 7'b1100000 || stall_cnt !== 16'd4) begin
      n_fail++;
      $display("FAIL mem_done got %b cnt %0d need 1100000 cnt 4",
               got(), stall_cnt);
    end
    next_cyc();
    set_idle();
    jump_id = 1;
    @(negedge clk);
    n_chk++;
    if (got() !== 7'b1101000) begin
      n_fail++;
      $display("FAIL mem_exit_run got %b need %b", got(), 7'b1101000);
    end
    next_cyc();
    set_idle();
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      n_chk++;
      if (got() !== 7'b0000010) begin
        n_fail++;
        $display("FAIL tmo_wait cyc%0d got %b need %b", c, got(), 7'b0000010);
      end
      next_cyc();
    end
    mem_req = 0;
    @(negedge clk);
    n_chk++;
    if (got() !== 7'b1100001 || stall_cnt !== 16'd16) begin
      n_fail++;
      $display("FAIL tmo_err got %b cnt %0d need 1100001 cnt 16",
               got(), stall_cnt);
    end
    n_chk++;
    if (s_stall_cnt !== 4'd15) begin
      n_fail++;
      $display("FAIL cnt_saturate got %0d need 15", s_stall_cnt);
    end
    next_cyc();
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (got() !== 7'b1100000) begin
      n_fail++;
      $display("FAIL tmo_rst got %b need %b", got(), 7'b1100000);
    end
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (mem_err !== 1'b0 || stall_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL tmo_cleared err %b cnt %0d need 0 0", mem_err, stall_cnt);
    end
    next_cyc();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    mem_req = 1; mem_ready = 0;
    repeat (3) next_cyc();
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    set_idle();
    @(negedge clk);
    n_chk++;
    if (got() !== 7'b1100000 || stall_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL rst_mid_stall got %b cnt %0d need 1100000 cnt 0",
               got(), stall_cnt);
    end
    next_cyc();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst         = ($urandom_range(0, 79) == 0);
      id_rs       = 3'($urandom_range(0, 7));
      id_rt       = 3'($urandom_range(0, 7));
      ex_rd       = 3'($urandom_range(0, 7));
      id_use_rs   = 1'($urandom_range(0, 1));
      id_use_rt   = 1'($urandom_range(0, 1));
      ex_mem_read = ($urandom_range(0, 2) != 0);
      jump_id     = ($urandom_range(0, 7) == 0);
      branch_ex   = ($urandom_range(0, 7) == 0);
      mem_req     = ($urandom_range(0, 2) == 0);
      mem_ready   = mem_req && ($urandom_range(0, 3) == 0);
      @(negedge clk);
      n_chk++;
      if (got() !== exp_out() || stall_cnt !== 16'(sat(m_cnt, 65535)) ||
          s_got() !== exp_out() || s_stall_cnt !== 4'(sat(m_cnt, 15))) begin
        n_fail++;
        $display("FAIL random cyc%0d got %b/%b cnt %0d/%0d need %b cnt %0d/%0d",
                 c, got(), s_got(), stall_cnt, s_stall_cnt, exp_out(),
                 sat(m_cnt, 65535), sat(m_cnt, 15));
      end
      next_cyc();
    end
    set_idle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    #1;
    test_reset();
    test_load_use(1'b1);
    test_load_use(1'b0);
    test_branch_priority();
    test_jump();
    test_mem_wait();
    test_timeout();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
